// File: rtl/load_store_unit_pkg.sv
// Purpose: shared definitions for the load/store unit: funct3 codes,
// memory command bit positions, transfer size codes, FSM state encoding
// and the load-result extender.
// Ports: none (package lsu_defs).
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MA_EN = 0;
  localparam int MA_WR = 1;
  localparam int MA_RD = 2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  // Memory returns the addressed byte/half in the low lanes; the upper
  // lanes are ignored and the extension is always rebuilt from funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [31:0] raw);
    logic [31:0] r;
    r = 32'h0;
    case (f3)
      F3_B:    r = {{24{raw[7]}}, raw[7:0]};
      F3_H:    r = {{16{raw[15]}}, raw[15:0]};
      F3_W:    r = raw;
      F3_BU:   r = {24'h0, raw[7:0]};
      F3_HU:   r = {16'h0, raw[15:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_addr_check.sv
// Purpose: effective-address adder with alignment and legality decode.
// Ports:
//   is_store_i    1=store request, 0=load request
//   funct3_i      RV32I load/store funct3
//   base_i        rs1 value
//   offset_i      sign-extended immediate
//   ea_o          base+offset, 32-bit wrap-around
//   misaligned_o  half on odd address or word not on a 4-byte boundary
//   fault_o       address beyond ADDR_W bits, or illegal funct3
module lsu_addr_check
  import lsu_defs::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] base_i,
  input  logic [31:0] offset_i,
  output logic [31:0] ea_o,
  output logic        misaligned_o,
  output logic        fault_o
);

  logic illegal_f3;
  logic out_of_range;

  assign ea_o = base_i + offset_i;

  always_comb begin
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      SZ_H:    misaligned_o = ea_o[0];
      SZ_W:    misaligned_o = |ea_o[1:0];
      default: misaligned_o = 1'b0;
    endcase
  end

  always_comb begin
    illegal_f3 = 1'b0;
    if (is_store_i) begin
      illegal_f3 = funct3_i[2] || (funct3_i == 3'b011);
    end else begin
      illegal_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                   (funct3_i == 3'b111);
    end
  end

  assign out_of_range = |ea_o[31:ADDR_W];
  assign fault_o      = illegal_f3 || out_of_range;

endmodule

// File: rtl/load_store_unit.sv
// Purpose: single-outstanding initiator for the byte-addressed data memory.
// Accepts one load/store, validates the effective address, issues one
// memory cycle, extends load data and returns a one-cycle response.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_is_store, req_funct3   operation select
//   req_base, req_offset       EA operands
//   req_wdata                  store data
//   rsp_valid                  one-cycle response pulse
//   rsp_rdata                  extended load result (0 for store/error)
//   rsp_misaligned, rsp_fault  error flags
//   memaccess, size, Memaddr, mem_wdata  registered memory command
//   mem_rdata                  memory read data, valid the cycle after a read
//
// state   | meaning
// IDLE    | ready for a request
// ACCESS  | memory command driven for exactly one cycle
// CAPTURE | load data present on mem_rdata, extend and latch it
// RESP    | rsp_valid high, result held
module load_store_unit
  import lsu_defs::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_offset,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misaligned,
  output logic              rsp_fault,
  output logic [2:0]        memaccess,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] Memaddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        memaccess_q, memaccess_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] memaddr_q, memaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              flt_q, flt_d;

  logic [31:0] ea;
  logic        chk_mis;
  logic        chk_flt;
  logic        accept;

  lsu_addr_check #(.ADDR_W(ADDR_W)) u_addr_check (
    .is_store_i   (req_is_store),
    .funct3_i     (req_funct3),
    .base_i       (req_base),
    .offset_i     (req_offset),
    .ea_o         (ea),
    .misaligned_o (chk_mis),
    .fault_o      (chk_flt)
  );

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    memaccess_d = '0;
    size_d      = size_q;
    memaddr_d   = memaddr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    mis_d       = mis_q;
    flt_d       = flt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d   = req_funct3;
          is_store_d = req_is_store;
          size_d     = req_funct3[1:0];
          memaddr_d  = ea[ADDR_W-1:0];
          wdata_d    = req_wdata;
          if (chk_mis || chk_flt) begin
            // Error: skip the memory entirely and report next cycle.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = 32'h0;
            mis_d       = chk_mis;
            flt_d       = chk_flt;
          end else begin
            state_d            = ACCESS;
            memaccess_d[MA_EN] = 1'b1;
            memaccess_d[MA_WR] = req_is_store;
            memaccess_d[MA_RD] = ~req_is_store;
          end
        end
      end
      ACCESS: begin
        if (is_store_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = 32'h0;
          mis_d       = 1'b0;
          flt_d       = 1'b0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rdata_d     = load_extend(funct3_q, mem_rdata);
        mis_d       = 1'b0;
        flt_d       = 1'b0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      memaccess_q <= '0;
      size_q      <= '0;
      memaddr_q   <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
      flt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      memaccess_q <= memaccess_d;
      size_q      <= size_d;
      memaddr_q   <= memaddr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      flt_q       <= flt_d;
    end
  end

  assign memaccess      = memaccess_q;
  assign size           = size_q;
  assign Memaddr        = memaddr_q;
  assign mem_wdata      = wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = mis_q;
  assign rsp_fault      = flt_q;

endmodule
